// File: rtl/interrupt_register.sv
// Eight sticky pending-interrupt bits: each bit sets while its request input is
// high at a rising clock edge and holds until cleared by index or by reset.
module interrupt_register (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       North_Button,
    input  logic       East_Button,
    input  logic       South_Button,
    input  logic       West_Button,
    input  logic       Sw3,
    input  logic       Sw2,
    input  logic       Sw1,
    input  logic       Sw0,
    input  logic [3:0] CLR,
    output logic [7:0] State
);

    logic [7:0] req;
    logic [7:0] clr_mask;
    logic [7:0] state_d;
    logic [7:0] state_q;

    assign req = {Sw3, Sw2, Sw1, Sw0, North_Button, East_Button, South_Button, West_Button};

    // CLR[3] low selects one bit to clear; CLR values 8..15 clear nothing.
    always_comb begin
        clr_mask = 8'h00;
        if (!CLR[3]) begin
            clr_mask[CLR[2:0]] = 1'b1;
        end
    end

    // The request OR comes after the clear, so a set and a clear on the same bit leaves it set.
    always_comb begin
        state_d = (state_q & ~clr_mask) | req;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= 8'h00;
        end else begin
            state_q <= state_d;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_interrupt_register.sv
// Directed bench for interrupt_register: hand-computed expected State values
// are queued by the driver and checked one cycle later by the scoreboard.
module tb_interrupt_register;

    logic       CLK;
    logic       RST_N;
    logic       North_Button;
    logic       East_Button;
    logic       South_Button;
    logic       West_Button;
    logic       Sw3;
    logic       Sw2;
    logic       Sw1;
    logic       Sw0;
    logic [3:0] CLR;
    logic [7:0] State;

    logic [7:0] exp_q[$];
    int         n_cmp;
    int         n_bad;

    interrupt_register dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .North_Button (North_Button),
        .East_Button  (East_Button),
        .South_Button (South_Button),
        .West_Button  (West_Button),
        .Sw3          (Sw3),
        .Sw2          (Sw2),
        .Sw1          (Sw1),
        .Sw0          (Sw0),
        .CLR          (CLR),
        .State        (State)
    );

    // Clock and reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: State=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // req is given in State bit order: {Sw3,Sw2,Sw1,Sw0,North,East,South,West}
    task automatic drive(input logic [7:0] req, input logic [3:0] clr);
        Sw3          = req[7];
        Sw2          = req[6];
        Sw1          = req[5];
        Sw0          = req[4];
        North_Button = req[3];
        East_Button  = req[2];
        South_Button = req[1];
        West_Button  = req[0];
        CLR          = clr;
    endtask

    task automatic step(input string tag, input logic [7:0] req, input logic [3:0] clr,
                        input logic [7:0] exp);
        logic [7:0] e;
        drive(req, clr);
        exp_q.push_back(exp);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_eq(tag, State, e);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST_N = 1'b0;
        drive(8'h00, 4'b1000);
        #1;
        check_eq("reset_initial", State, 8'h00);

        // Inputs active during reset must not set anything
        drive(8'hFF, 4'b1000);
        @(posedge CLK);
        #1;
        check_eq("reset_hold_inputs", State, 8'h00);
        drive(8'h00, 4'b1000);
        #2;
        RST_N = 1'b1;

        // Set capture and sticky hold
        step("set_capture", 8'b1001_1010, 4'b1000, 8'b1001_1010);
        for (int i = 0; i < 3; i++) step("sticky_hold", 8'h00, 4'b1000, 8'b1001_1010);

        // Indexed clear sequence
        step("clr7", 8'h00, 4'd7, 8'b0001_1010);
        step("clr4", 8'h00, 4'd4, 8'b0000_1010);
        step("clr3", 8'h00, 4'd3, 8'b0000_0010);
        step("clr1", 8'h00, 4'd1, 8'b0000_0000);

        // Set wins over clear of the same bit
        step("collide_set", 8'h01, 4'b0000, 8'h01);
        step("collide_clr", 8'h00, 4'b0000, 8'h00);

        // Clear of one bit alongside setting others
        step("set_sw1_east", 8'b0010_0100, 4'b1000, 8'h24);
        step("clr5_set6", 8'b0100_0000, 4'd5, 8'h44);
        step("clr2", 8'h00, 4'd2, 8'h40);
        step("clr6", 8'h00, 4'd6, 8'h00);

        // Input-to-bit mapping, one source at a time
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h01 << i;
            step($sformatf("map_set%0d", i), b, 4'b1000, b);
            step($sformatf("map_clr%0d", i), 8'h00, 4'(i), 8'h00);
        end

        // No-op clear codes
        step("set_55", 8'h55, 4'b1000, 8'h55);
        step("noop_f", 8'h00, 4'b1111, 8'h55);
        step("noop_9", 8'h00, 4'b1001, 8'h55);
        step("noop_c", 8'h00, 4'b1100, 8'h55);
        step("noop_f2", 8'h00, 4'b1111, 8'h55);

        // Asynchronous reset mid-operation
        step("set_ff", 8'hFF, 4'b1000, 8'hFF);
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("async_reset", State, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            check_eq("reset_held", State, 8'h00);
        end
        #2;
        RST_N = 1'b1;
        step("post_reset_set", 8'h08, 4'b1000, 8'h08);
        step("post_reset_hold", 8'h00, 4'b1000, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
